// File: rtl/stream_mux_pkg.sv
// Shared encodings for the stream_mux slice: select-mode constants and the
// packet lock-state enum used when STREAM_MUX_LAST_EN is defined.
package stream_mux_pkg;

  localparam logic MODE_ADDR = 1'b0;
  localparam logic MODE_RR   = 1'b1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Round-robin search: grants the first requesting channel at or above ptr,
// wrapping from CHANNELS-1 back to 0.
module rr_arbiter #(
  parameter int CHANNELS = 4,
  parameter int SELW     = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SELW-1:0]     ptr,
  output logic [CHANNELS-1:0] grant,
  output logic [SELW-1:0]     grant_idx,
  output logic                any
);

  logic [SELW-1:0] idx_s;

  // priority scan starting at ptr; SELW-bit addition provides the wrap
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx_s     = ptr;
    for (int k = 0; k < CHANNELS; k++) begin
      idx_s = ptr + SELW'(k);
      if (!any && req[idx_s]) begin
        any          = 1'b1;
        grant[idx_s] = 1'b1;
        grant_idx    = idx_s;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/stream_mux.sv
// N-to-1 valid/ready stream multiplexer with addressed or round-robin select
// and a one-deep output register. STREAM_MUX_LAST_EN adds packet locking.
module stream_mux
  import stream_mux_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SELW     = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      mode,
  input  logic [SELW-1:0]           address,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SELW-1:0]           out_chan
`ifdef STREAM_MUX_LAST_EN
  ,
  input  logic [CHANNELS-1:0]       in_last,
  output logic                      out_last
`endif
);

  logic [WIDTH-1:0]    out_data_r;
  logic                out_valid_r;
  logic [SELW-1:0]     out_chan_r;
  logic [SELW-1:0]     rr_ptr_r;
  logic [CHANNELS-1:0] arb_grant_s;
  logic [SELW-1:0]     arb_idx_s;
  logic                arb_any_s;
  logic [CHANNELS-1:0] ready_s;
  logic [SELW-1:0]     sel_s;
  logic                free_s;
  logic                xfer_s;
  logic                last_s;

  rr_arbiter #(.CHANNELS(CHANNELS), .SELW(SELW)) u_rr_arbiter (
    .req       (in_valid),
    .ptr       (rr_ptr_r),
    .grant     (arb_grant_s),
    .grant_idx (arb_idx_s),
    .any       (arb_any_s)
  );

`ifdef STREAM_MUX_LAST_EN
  lock_state_t     lock_state_r, lock_next_s;
  logic [SELW-1:0] lock_chan_r, lock_chan_next_s;
  logic            out_last_r;
`endif

  assign free_s = !out_valid_r || out_ready;

  // channel selection; an open packet pins the grant to its channel
  always_comb begin
    sel_s   = address;
    ready_s = '0;
`ifdef STREAM_MUX_LAST_EN
    if (lock_state_r == LOCKED) begin
      sel_s                = lock_chan_r;
      ready_s[lock_chan_r] = 1'b1;
    end else
`endif
    if (mode == MODE_RR) begin
      sel_s   = arb_idx_s;
      ready_s = arb_any_s ? arb_grant_s : '0;
    end else begin
      sel_s            = address;
      ready_s[address] = 1'b1;
    end
  end

  assign in_ready = (reset_n && free_s) ? ready_s : '0;
  assign xfer_s   = |(in_valid & in_ready);

`ifdef STREAM_MUX_LAST_EN
  assign last_s = in_last[sel_s];

  // lock FSM next state: open on a non-last beat, close on the last beat
  always_comb begin
    lock_next_s      = lock_state_r;
    lock_chan_next_s = lock_chan_r;
    case (lock_state_r)
      IDLE: begin
        if (xfer_s && !last_s) begin
          lock_next_s      = LOCKED;
          lock_chan_next_s = sel_s;
        end else begin
          lock_next_s = IDLE;
        end
      end
      LOCKED: begin
        if (xfer_s && last_s) begin
          lock_next_s = IDLE;
        end else begin
          lock_next_s = LOCKED;
        end
      end
      default: lock_next_s = IDLE;
    endcase
  end

  // lock FSM state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lock_state_r <= IDLE;
      lock_chan_r  <= '0;
    end else begin
      lock_state_r <= lock_next_s;
      lock_chan_r  <= lock_chan_next_s;
    end
  end

  // last flag travels with the data beat
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_last_r <= 1'b0;
    end else if (free_s && xfer_s) begin
      out_last_r <= last_s;
    end else begin
      out_last_r <= out_last_r;
    end
  end

  assign out_last = out_last_r;
`else
  assign last_s = 1'b1;
`endif

  // output register and round-robin pointer (pointer moves only at packet end)
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_chan_r  <= '0;
      rr_ptr_r    <= '0;
    end else begin
      if (free_s) begin
        out_valid_r <= xfer_s;
        if (xfer_s) begin
          out_data_r <= in_data[sel_s*WIDTH +: WIDTH];
          out_chan_r <= sel_s;
        end
      end
      if (xfer_s && last_s && (mode == MODE_RR)) begin
        rr_ptr_r <= sel_s + SELW'(1);
      end
    end
  end

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign out_chan  = out_chan_r;

endmodule

// File: tb/tb_stream_mux.sv
// Randomized self-checking bench for stream_mux with a queue-free behavioural
// model; directed sequences pin the model. Honours STREAM_MUX_LAST_EN.
module tb_stream_mux;

  localparam int CH = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          reset_n, mode, out_valid, out_ready;
  logic [SW-1:0] address, out_chan;
  logic [CH*W-1:0] in_data;
  logic [CH-1:0] in_valid, in_ready;
  logic [W-1:0]  out_data;
`ifdef STREAM_MUX_LAST_EN
  logic [CH-1:0] in_last;
  logic          out_last;
  bit            m_last;
`endif

  int errors = 0;
  int checks = 0;

  bit         m_valid;
  logic [W-1:0] m_data;
  int         m_chan, m_ptr, m_lockch;
  bit         m_locked;
  logic [W-1:0] held;
  int         exp35 [5] = '{0, 1, 2, 3, 0};

  always #5 clk = ~clk;

  stream_mux #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk(clk), .reset_n(reset_n), .mode(mode), .address(address),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_chan(out_chan)
`ifdef STREAM_MUX_LAST_EN
    , .in_last(in_last), .out_last(out_last)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // which channel the rules pick this cycle, and whether any is eligible
  function automatic int pick(output bit ok);
    ok = 1'b0;
    if (m_locked) begin ok = 1'b1; return m_lockch; end
    if (mode == 1'b0) begin ok = 1'b1; return int'(address); end
    for (int k = 0; k < CH; k++) begin
      if (in_valid[(m_ptr + k) % CH]) begin ok = 1'b1; return (m_ptr + k) % CH; end
    end
    return 0;
  endfunction

  function automatic logic [CH-1:0] exp_ready();
    bit ok;
    int c;
    logic [CH-1:0] r;
    r = '0;
    c = pick(ok);
    if (reset_n && (!m_valid || out_ready) && ok) r[c] = 1'b1;
    return r;
  endfunction

  task automatic model_update();
    bit ok, lb;
    int c;
    if (!reset_n) begin
      m_valid = 0; m_data = '0; m_chan = 0; m_ptr = 0; m_locked = 0; m_lockch = 0;
`ifdef STREAM_MUX_LAST_EN
      m_last = 0;
`endif
    end else if (!m_valid || out_ready) begin
      c = pick(ok);
      if (ok && in_valid[c]) begin
        m_valid = 1; m_data = in_data[c*W +: W]; m_chan = c;
        lb = 1'b1;
`ifdef STREAM_MUX_LAST_EN
        lb = in_last[c];
        m_last = lb;
        if (!m_locked && !lb) begin m_locked = 1; m_lockch = c; end
        else if (m_locked && lb) m_locked = 0;
`endif
        if (mode == 1'b1 && lb) m_ptr = (c + 1) % CH;
      end else begin
        m_valid = 0;
      end
    end
  endtask

  // compare against the model, then advance one clock; called at negedge
  task automatic step();
    #1;
    check("in_ready", 32'(in_ready), 32'(exp_ready()));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      check("out_data", 32'(out_data), 32'(m_data));
      check("out_chan", 32'(out_chan), 32'(m_chan));
`ifdef STREAM_MUX_LAST_EN
      check("out_last", 32'(out_last), 32'(m_last));
`endif
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    reset_n = 0; mode = 0; address = 2'd1; in_data = '0; in_valid = 4'b1111; out_ready = 1;
`ifdef STREAM_MUX_LAST_EN
    in_last = 4'b1111;
`endif
    m_valid = 0; m_data = '0; m_chan = 0; m_ptr = 0; m_locked = 0; m_lockch = 0;
    @(negedge clk);
    step(); step();
    #1;
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_chan", 32'(out_chan), 32'h0);

    // addressed select of channel 2
    reset_n = 1; mode = 0; address = 2'd2; in_valid = 4'b1111; in_data = 32'h44A52211;
    #1 check("addr_ready", 32'(in_ready), 32'h4);
    step();
    check("addr_data", 32'(out_data), 32'hA5);
    check("addr_chan", 32'(out_chan), 32'h2);

    // round-robin over all-valid channels
    mode = 1;
    for (int i = 0; i < 5; i++) begin
      in_data = $urandom;
      step();
      check("rr_seq", 32'(out_chan), 32'(exp35[i]));
    end

    // sparse valid with pointer at 1
    in_valid = 4'b1001;
    step(); check("rr_wrap_a", 32'(out_chan), 32'h3);
    step(); check("rr_wrap_b", 32'(out_chan), 32'h0);

    // backpressure holds the beat
    in_valid = 4'b1111; out_ready = 0; held = out_data;
    for (int i = 0; i < 3; i++) begin
      in_data = $urandom;
      #1 check("stall_ready", 32'(in_ready), 32'h0);
      step();
      check("stall_data", 32'(out_data), 32'(held));
    end
    out_ready = 1; in_data = 32'h00005C00;
    step();
    check("unstall_chan", 32'(out_chan), 32'h1);
    check("unstall_data", 32'(out_data), 32'h5C);
    check("unstall_valid", 32'(out_valid), 32'h1);

    // drain with no input
    in_valid = 4'b0000;
    step(); check("drain_valid", 32'(out_valid), 32'h0);

    // reset with a held beat
    in_valid = 4'b1111; out_ready = 0;
    step();
    reset_n = 0;
    step(); check("rst_held_valid", 32'(out_valid), 32'h0);
    reset_n = 1;
    step(); check("rst_ptr_chan", 32'(out_chan), 32'h0);
    out_ready = 1;

`ifdef STREAM_MUX_LAST_EN
    // three-beat packet on channel 1 while channel 0 also requests
    reset_n = 0; step(); reset_n = 1; mode = 1;
    in_valid = 4'b0001; in_last = 4'b1111; step();
    in_valid = 4'b0011; in_last = 4'b0000;
    step(); check("pkt_b1", 32'(out_chan), 32'h1);
    step(); check("pkt_b2", 32'(out_chan), 32'h1);
    in_last = 4'b0010;
    step(); check("pkt_b3", 32'(out_chan), 32'h1);
    in_last = 4'b1111;
    step(); check("pkt_after", 32'(out_chan), 32'h0);
`endif

    for (int i = 0; i < 3000; i++) begin
      reset_n   = ($urandom % 64) != 0;
      if ($urandom % 8 == 0) mode = 1'($urandom);
      address   = SW'($urandom);
      in_data   = $urandom;
      in_valid  = CH'($urandom);
      out_ready = ($urandom % 4) != 0;
`ifdef STREAM_MUX_LAST_EN
      in_last   = CH'($urandom) & CH'($urandom);
`endif
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_mux.md
STREAM_MUX -- requirements
Module: stream_mux

Interface
REQ-001 Parameter: WIDTH, default 8, data bits per channel.
REQ-002 Parameter: CHANNELS, default 4, number of input channels; power of two, 2..16.
REQ-003 Parameter: SELW, derived as clog2(CHANNELS), width of address and grant index.
REQ-004 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-005 Port: reset_n  in  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-006 Port: mode  in  1  0 = addressed select, 1 = round-robin select.
REQ-007 Port: address  in  SELW  channel index used when mode=0.
REQ-008 Port: in_data  in  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 Port: in_valid  in  CHANNELS  per-channel valid.
REQ-010 Port: in_ready  out  CHANNELS  per-channel ready; at most one bit high per cycle.
REQ-011 Port: out_data  out  WIDTH  registered selected data.
REQ-012 Port: out_valid  out  1  registered output valid.
REQ-013 Port: out_ready  in  1  downstream ready.
REQ-014 Port: out_chan  out  SELW  registered index of channel that supplied out_data.

Function
REQ-015 Input transfer on channel i SHALL occur when in_valid[i] and in_ready[i] are both high at a clk edge.
REQ-016 Output register SHALL be free when out_valid=0 or out_ready=1; in_ready SHALL be all-zero when not free.
REQ-017 Mode 0: in_ready[address] SHALL be high only when the register is free; other bits low.
REQ-018 Mode 1: grant SHALL go to the first valid channel at or after rr_ptr, searching upward with wrap from CHANNELS-1 to 0.
REQ-019 Mode 1: after a transfer from channel g, rr_ptr SHALL become (g+1) mod CHANNELS; no transfer leaves rr_ptr unchanged.
REQ-020 Latency: data accepted at edge N SHALL appear on out_data/out_valid/out_chan after edge N, one cycle.
REQ-021 Simultaneous output consume and input accept in the same cycle SHALL load new data, keeping out_valid high; full throughput of one beat per cycle.
REQ-022 out_valid high with out_ready low SHALL hold out_data, out_chan stable.
REQ-023 No valid input while the register is free: out_valid SHALL drop to 0 after the consuming edge.
REQ-024 Change of mode or address SHALL take effect in the same cycle's grant, except while LOCKED (REQ-030).

Reset
REQ-025 reset_n low at a clk edge: out_valid=0, out_data=0, out_chan=0, rr_ptr=0, lock state IDLE.
REQ-026 in_ready SHALL be all-zero while reset_n is low.
REQ-027 Reset asserted mid-packet or with out_valid high SHALL discard the held beat without handshake.

Configuration
REQ-028 Macro STREAM_MUX_LAST_EN SHALL add ports in_last (in, CHANNELS) and out_last (out, 1, registered with out_data, reset 0).
REQ-029 With STREAM_MUX_LAST_EN: lock FSM IDLE -> LOCKED on transfer with in_last=0; LOCKED -> IDLE on transfer with in_last=1; IDLE stays IDLE on single-beat packet.
REQ-030 In LOCKED the grant SHALL stay on the locked channel regardless of mode, address or rr_ptr; rr_ptr SHALL advance only on the last beat.
REQ-031 Without STREAM_MUX_LAST_EN: no last ports, no lock FSM, grant re-evaluated every transfer.

Structure
REQ-032 Package stream_mux_pkg SHALL hold the mode encoding constants and the lock-state enum (IDLE, LOCKED).
REQ-033 Round-robin search SHALL be a sub-module rr_arbiter (inputs req, ptr; outputs grant one-hot, grant index, any).

Verification
REQ-034 CHANNELS=4, mode=0, address=2, in_valid=4'b1111, in_data ch2=8'hA5, out_ready=1 -> in_ready=4'b0100; next cycle out_data=8'hA5, out_chan=2.
REQ-035 Mode=1, all valid, out_ready=1 for 5 cycles -> out_chan sequence 0,1,2,3,0.
REQ-036 Mode=1, in_valid=4'b1001, rr_ptr=1 -> grant channel 3, then channel 0.
REQ-037 out_valid=1, out_ready=0 for 3 cycles -> in_ready=0, out_data unchanged; out_ready=1 -> new beat loaded same edge.
REQ-038 LAST_EN: ch1 sends 3 beats (last on 3rd) while ch0 valid in mode 1 -> out_chan 1,1,1 then 0.
REQ-039 reset_n=0 with out_valid=1 mid-packet -> next cycle out_valid=0, rr_ptr=0, state IDLE.
